// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared segment/code constants and monitor state enum
package fnd_pkg;

  // Segment patterns, bit6=a .. bit0=g, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    LOST
  } state_e;

endpackage

// File: rtl/fnd_seg_decode.sv
// rtl/fnd_seg_decode.sv - combinational 7-segment pattern to 4-bit code decoder
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       illegal_o
);

  // Map the known patterns; anything else is flagged and reads as blank
  always_comb begin
    code_o    = CODE_BLANK;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_DASH:  code_o = CODE_DASH;
      SEG_BLANK: code_o = CODE_BLANK;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_monitor.sv
// rtl/fnd_monitor.sv - two-digit multiplexed 7-segment link monitor with debounce and timeout
module fnd_monitor
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_i,
  input  logic       sel1_i,
  input  logic       sel2_i,
  input  logic       err_clr_i,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic       valid_o,
  output logic       changed_o,
  output logic       err_o
);

  // +1 so a power-of-two parameter still fits its own terminal value
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

  logic [6:0]    seg_q;
  logic          sel1_q, sel2_q;
  logic [3:0]    code;
  logic          illegal;
  logic [1:0]    sample, commit, chg, timeout;
  logic [3:0]    cand_q [2];
  logic [3:0]    cand_d [2];
  logic [3:0]    dig_q  [2];
  logic [3:0]    dig_d  [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [TW-1:0] to_q   [2];
  logic [TW-1:0] to_d   [2];
  logic [1:0]    com_q, com_d, reach_q, reach_d;
  state_e        state_q, state_d;
  logic          enter_lost;
  logic          err_q, err_d, changed_q, changed_d;

  fnd_seg_decode u_dec (
    .seg_i    (seg_q),
    .code_o   (code),
    .illegal_o(illegal)
  );

  // Single input register stage; everything downstream sees only these copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= '0;
      sel1_q <= 1'b0;
      sel2_q <= 1'b0;
    end else begin
      seg_q  <= seg_i;
      sel1_q <= sel1_i;
      sel2_q <= sel2_i;
    end
  end

  // Per-digit debounce, commit and timeout; index 0 is digit 1, index 1 is digit 2
  always_comb begin
    sample  = {sel2_q & ~sel1_q, sel1_q & ~sel2_q};
    commit  = '0;
    chg     = '0;
    timeout = '0;
    for (int i = 0; i < 2; i++) begin
      cand_d[i] = cand_q[i];
      cnt_d[i]  = cnt_q[i];
      dig_d[i]  = dig_q[i];
      to_d[i]   = to_q[i];
      if (sample[i]) begin
        to_d[i] = '0;
        if (illegal) begin
          cnt_d[i] = '0;
        end else if (code == cand_q[i]) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cand_d[i] = code;
          cnt_d[i]  = CW'(1);
        end
        commit[i] = !illegal && (cnt_d[i] == CNT_MAX);
      end else if (to_q[i] != TO_MAX) begin
        to_d[i] = to_q[i] + 1'b1;
      end
      timeout[i] = (to_d[i] == TO_MAX);
      if (commit[i]) begin
        dig_d[i] = cand_d[i];
        chg[i]   = (cand_d[i] != dig_q[i]);
      end
    end
  end

  // Link state, progress flags, sticky error and the change pulse
  always_comb begin
    state_d    = state_q;
    enter_lost = 1'b0;
    case (state_q)
      IDLE:    if (&(com_q | commit)) state_d = LOCKED;
      LOCKED:  if (|timeout) begin
                 state_d    = LOST;
                 enter_lost = 1'b1;
               end
      LOST:    if (&(reach_q | commit)) state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    com_d     = com_q | commit;
    reach_d   = enter_lost ? 2'b00 : (reach_q | commit);
    // a new error wins over a simultaneous clear
    err_d     = (err_q & ~err_clr_i) | (sel1_q & sel2_q) | ((|sample) & illegal);
    changed_d = |chg;
  end

  // Register all monitor state; entering LOST restarts both stability counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cand_q[i] <= CODE_BLANK;
        dig_q[i]  <= CODE_BLANK;
        cnt_q[i]  <= '0;
        to_q[i]   <= '0;
      end
      com_q     <= '0;
      reach_q   <= '0;
      state_q   <= IDLE;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cand_q[i] <= cand_d[i];
        dig_q[i]  <= dig_d[i];
        cnt_q[i]  <= enter_lost ? '0 : cnt_d[i];
        to_q[i]   <= to_d[i];
      end
      com_q     <= com_d;
      reach_q   <= reach_d;
      state_q   <= state_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign digit1_o  = dig_q[0];
  assign digit2_o  = dig_q[1];
  assign valid_o   = (state_q == LOCKED);
  assign changed_o = changed_q;
  assign err_o     = err_q;

endmodule

// File: doc/fnd_monitor.md
FND_MONITOR -- requirements
Module: fnd_monitor

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical samples of one digit needed to commit it; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 20000: cycles without a select for one digit before the link is declared lost; at 1 MHz this is two 100 Hz multiplex periods; legal range STABLE_CNT..2^20-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg_i  input  7  segment pattern, bit6=a .. bit0=g, active-high.
REQ-006 sel1_i  input  1  high: seg_i carries digit 1 (ones).
REQ-007 sel2_i  input  1  high: seg_i carries digit 2 (tens).
REQ-008 err_clr_i  input  1  one-cycle pulse that clears err_o.
REQ-009 digit1_o  output  4  committed code of digit 1.
REQ-010 digit2_o  output  4  committed code of digit 2.
REQ-011 valid_o  output  1  high while the state is LOCKED.
REQ-012 changed_o  output  1  one-cycle pulse when either committed digit changes value.
REQ-013 err_o  output  1  sticky flag for an illegal pattern or an illegal select.

Function
REQ-014 seg_i, sel1_i and sel2_i shall be registered once, and all decoding shall use the registered copies.
REQ-015 Decode: standard 0-9 patterns map to codes 0-9, 7'b0000001 maps to 4'hA (dash), 7'b0000000 maps to 4'hF (blank), and any other pattern is illegal.
REQ-016 A sample of digit d exists only when exactly one registered select is high; when both or neither are high there is no sample.
REQ-017 Both selects high shall set err_o.
REQ-018 For each digit keep a candidate code and a saturating counter cnt_d: same code as candidate gives cnt_d+1 (saturate at STABLE_CNT); different legal code gives candidate=code, cnt_d=1; illegal pattern gives cnt_d=0 and sets err_o.
REQ-019 Commit: when cnt_d reaches STABLE_CNT, digit_d_o takes the candidate.
REQ-020 changed_o shall pulse on the same edge as the commit only if the committed value differs from the previous one.
REQ-021 If both digits commit changed values on the same edge, changed_o shall give a single one-cycle pulse.
REQ-022 Latency: with identical samples presented on edges E..E+STABLE_CNT-1, the new digit_d_o and changed_o shall be visible after edge E+STABLE_CNT.
REQ-023 Each digit has a timeout counter that is cleared by any sample of that digit, counts otherwise, and saturates at TIMEOUT.
REQ-024 State machine IDLE: move to LOCKED once both digits have committed since reset.
REQ-025 State machine LOCKED: move to LOST when either timeout counter reaches TIMEOUT.
REQ-026 State machine LOST: move to LOCKED when both digits have reached STABLE_CNT again since entering LOST.
REQ-027 Entering LOST shall clear both cnt_d values, and digit outputs shall hold their last values.
REQ-028 A commit and a timeout of the other digit on the same edge shall result in LOST, with the commit still applied.
REQ-029 err_clr_i together with a new error on the same edge shall leave err_o set.
REQ-030 Counters shall be sized by $clog2 of their parameter.
REQ-031 No counter shall wrap.

Reset
REQ-032 While rst is high: digit1_o=digit2_o=4'hF, valid_o=0, changed_o=0, err_o=0, state IDLE, all counters and candidates cleared (candidate=4'hF).
REQ-033 A reset asserted mid-operation takes effect immediately, asynchronously, and abandons any partial count.

Structure
REQ-034 Shared package fnd_pkg shall hold the segment constants, the 4-bit code constants (CODE_DASH=4'hA, CODE_BLANK=4'hF) and the state enum {IDLE, LOCKED, LOST}.
REQ-035 Sub-module fnd_seg_decode: combinational, seg[6:0] in, code[3:0] and illegal out; fnd_monitor shall instantiate it once.

Verification
REQ-036 Reset, then 5000 cycles of sel1=1 with seg_i=7'b1111011, then 5000 cycles of sel2=1 with seg_i=7'b1011011 -> digit1_o=9, then digit2_o=5, changed_o pulses twice, valid_o=1 after the digit-2 commit.
REQ-037 STABLE_CNT=4: present seg for '3' on sel1 for 3 cycles, then '8' for 4 cycles -> digit1_o never shows 3 and shows 8 after the 4th '8' edge plus one.
REQ-038 Locked link, then hold sel2 low for TIMEOUT cycles -> valid_o falls on the TIMEOUT-th cycle with digits held; resuming both digits for STABLE_CNT samples each -> valid_o=1 again.
REQ-039 seg_i=7'b1010101 on sel1, then sel1=sel2=1 -> err_o=1 and digit1_o unchanged; err_clr_i pulse -> err_o=0; err_clr_i on the same edge as a new error -> err_o stays 1.
REQ-040 Assert rst mid-count (cnt_d=2) and mid-LOCKED -> all outputs take their reset values immediately, without a clock edge.
